// File: rtl/mem_stage_unit.sv
// MEM stage: runs one data-memory transaction per load/store over a req/ack bus,
// stalls upstream while it is outstanding, and registers the MEM/WB outputs.
module mem_stage_unit #(
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:3]        ex_control,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_dst_reg,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic [DATA_W-1:0] wb_alu_result,
    output logic [REG_W-1:0]  wb_dst_reg,
    output logic              misalign_err,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              dmem_req_q, dmem_we_q;
    logic [DATA_W-1:0] dmem_addr_q, dmem_wdata_q;
    logic              wb_reg_write_q, wb_mem_to_reg_q;
    logic [DATA_W-1:0] wb_mem_data_q, wb_alu_result_q;
    logic [REG_W-1:0]  wb_dst_reg_q;
    logic              misalign_err_q, bus_err_q;

    logic mem_write, mem_read, reg_write, mem_to_reg;
    logic memop, aligned, timeout;

    assign mem_write  = ex_control[0];
    assign mem_read   = ex_control[1];
    assign reg_write  = ex_control[2];
    assign mem_to_reg = ex_control[3];
    assign memop      = mem_write | mem_read;
    assign aligned    = (ex_alu_result[1:0] == 2'b00);
    assign timeout    = (cnt_q == CNT_LAST);

    // Stall drops in the completing/aborting cycle so EX/MEM advances on that same edge.
    always_comb begin
        stall = 1'b0;
        case (state_q)
            IDLE:    stall = memop & aligned;
            ACCESS:  stall = !dmem_ack && !timeout;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            dmem_req_q      <= 1'b0;
            dmem_we_q       <= 1'b0;
            dmem_addr_q     <= '0;
            dmem_wdata_q    <= '0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_mem_data_q   <= '0;
            wb_alu_result_q <= '0;
            wb_dst_reg_q    <= '0;
            misalign_err_q  <= 1'b0;
            bus_err_q       <= 1'b0;
        end else begin
            // Every cycle defaults to a bubble in MEM/WB; only retiring cycles overwrite it.
            misalign_err_q  <= 1'b0;
            bus_err_q       <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_mem_data_q   <= '0;
            wb_alu_result_q <= '0;
            wb_dst_reg_q    <= '0;
            case (state_q)
                IDLE: begin
                    if (!memop) begin
                        wb_reg_write_q  <= reg_write;
                        wb_mem_to_reg_q <= mem_to_reg;
                        wb_alu_result_q <= ex_alu_result;
                        wb_dst_reg_q    <= ex_dst_reg;
                    end else if (!aligned) begin
                        misalign_err_q <= 1'b1;
                    end else begin
                        state_q      <= ACCESS;
                        cnt_q        <= '0;
                        dmem_req_q   <= 1'b1;
                        dmem_we_q    <= mem_write;
                        dmem_addr_q  <= ex_alu_result;
                        dmem_wdata_q <= ex_store_data;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        // ex_* are still the frozen values of the instruction being retired.
                        wb_reg_write_q  <= reg_write;
                        wb_mem_to_reg_q <= dmem_we_q ? 1'b0 : mem_to_reg;
                        wb_mem_data_q   <= dmem_we_q ? '0 : dmem_rdata;
                        wb_alu_result_q <= ex_alu_result;
                        wb_dst_reg_q    <= ex_dst_reg;
                        dmem_req_q      <= 1'b0;
                        cnt_q           <= '0;
                        state_q         <= IDLE;
                    end else if (timeout) begin
                        bus_err_q  <= 1'b1;
                        dmem_req_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_req      = dmem_req_q;
    assign dmem_we       = dmem_we_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;
    assign wb_mem_data   = wb_mem_data_q;
    assign wb_alu_result = wb_alu_result_q;
    assign wb_dst_reg    = wb_dst_reg_q;
    assign misalign_err  = misalign_err_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// Bench for mem_stage_unit: directed and random transactions checked against a
// transaction-level model of cycle counts and MEM/WB results.
module tb_mem_stage_unit;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int T  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [0:3]    ex_control;
    logic [DW-1:0] ex_alu_result, ex_store_data;
    logic [RW-1:0] ex_dst_reg;
    logic          dmem_req, dmem_we, dmem_ack;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic          stall;
    logic          wb_reg_write, wb_mem_to_reg;
    logic [DW-1:0] wb_mem_data, wb_alu_result;
    logic [RW-1:0] wb_dst_reg;
    logic          misalign_err, bus_err;

    int tests = 0;
    int fails = 0;

    mem_stage_unit #(.DATA_W(DW), .REG_W(RW), .ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .ex_control(ex_control), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_dst_reg(ex_dst_reg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_mem_data(wb_mem_data), .wb_alu_result(wb_alu_result),
        .wb_dst_reg(wb_dst_reg), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ctrl is written as in the spec strings: ctrl[3]=MemWrite .. ctrl[0]=MemToReg.
    // lat = ACCESS cycle (1-based) on which memory acks; 0 means never.
    task automatic run_txn(input logic [3:0] ctrl, input logic [31:0] alu, input logic [31:0] sd,
                           input logic [4:0] dst, input int lat, input logic [31:0] rd,
                           input string name);
        bit   mw, mr, rwr, m2r, memop, aligned, completes, done;
        int   n_exp, n_stall, n_req, acc, cyc;
        logic st;
        logic e_rw, e_m2r, e_mis, e_bus;
        logic [31:0] e_data, e_alu;
        logic [4:0]  e_dst;
        mw = ctrl[3]; mr = ctrl[2]; rwr = ctrl[1]; m2r = ctrl[0];
        memop   = mw | mr;
        aligned = (alu[1:0] == 2'b00);
        // Model: count of stalled cycles / request cycles and the retired MEM/WB contents.
        n_exp = 0; completes = 0; e_mis = 0; e_bus = 0;
        e_rw = 0; e_m2r = 0; e_data = 0; e_alu = 0; e_dst = 0;
        if (!memop) begin
            e_rw = rwr; e_m2r = m2r; e_alu = alu; e_dst = dst;
        end else if (!aligned) begin
            e_mis = 1;
        end else begin
            completes = (lat >= 1 && lat <= T);
            n_exp     = completes ? lat : T;
            if (completes) begin
                e_rw = rwr; e_m2r = mw ? 1'b0 : m2r; e_data = mw ? 32'h0 : rd;
                e_alu = alu; e_dst = dst;
            end else begin
                e_bus = 1;
            end
        end

        ex_control = ctrl; ex_alu_result = alu; ex_store_data = sd; ex_dst_reg = dst;
        dmem_ack = 1'b0; dmem_rdata = rd;
        n_stall = 0; n_req = 0; acc = 0; cyc = 0; done = 0;
        while (!done && cyc < 30) begin
            @(negedge clk);
            if (dmem_req) begin
                acc++;
                dmem_ack = (acc == lat);
                if (acc == 1) begin
                    check({name, "/we"},    32'(dmem_we), 32'(mw));
                    check({name, "/addr"},  dmem_addr, alu);
                    if (mw) check({name, "/wdata"}, dmem_wdata, sd);
                end
            end
            #1;
            st = stall;
            if (st) n_stall++;
            if (dmem_req) n_req++;
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            cyc++;
            if (!st) done = 1;
        end
        check({name, "/retired"},  32'(done), 32'd1);
        check({name, "/stall_n"},  n_stall, n_exp);
        check({name, "/req_n"},    n_req, n_exp);
        check({name, "/req_low"},  32'(dmem_req), 32'd0);
        check({name, "/wb_rw"},    32'(wb_reg_write), 32'(e_rw));
        check({name, "/wb_m2r"},   32'(wb_mem_to_reg), 32'(e_m2r));
        check({name, "/misalign"}, 32'(misalign_err), 32'(e_mis));
        check({name, "/bus_err"},  32'(bus_err), 32'(e_bus));
        if (e_rw || e_m2r || (!memop) || completes) begin
            check({name, "/wb_data"}, wb_mem_data, e_data);
            check({name, "/wb_alu"},  wb_alu_result, e_alu);
            check({name, "/wb_dst"},  32'(wb_dst_reg), 32'(e_dst));
        end
        $display("[TB] %s ctrl=%b addr=0x%08h lat=%0d stall_cycles=%0d", name, ctrl, alu, lat, n_stall);
    endtask

    initial begin
        logic [3:0]  r_ctrl;
        logic [31:0] r_alu;
        int          r_lat;

        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
        ex_control = 4'b0000; ex_alu_result = '0; ex_store_data = '0; ex_dst_reg = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/req",      32'(dmem_req), 0);
        check("reset/stall",    32'(stall), 0);
        check("reset/wb_rw",    32'(wb_reg_write), 0);
        check("reset/wb_alu",   wb_alu_result, 0);
        check("reset/misalign", 32'(misalign_err), 0);
        check("reset/bus_err",  32'(bus_err), 0);
        rst = 1'b0;

        run_txn(4'b0010, 32'h0000_1234, 32'h0,  5'd7,  0, 32'h0,         "alu_op");
        run_txn(4'b0111, 32'h0000_0040, 32'h0,  5'd9,  3, 32'hDEAD_BEEF, "load_ack3");
        run_txn(4'b1000, 32'h0000_0010, 32'h55, 5'd3,  1, 32'hFFFF_FFFF, "store_ack1");
        run_txn(4'b0111, 32'h0000_0042, 32'h0,  5'd4,  1, 32'h1234_5678, "misaligned");
        run_txn(4'b0111, 32'h0000_0044, 32'h0,  5'd5,  0, 32'h0BAD_F00D, "timeout");
        run_txn(4'b0111, 32'h0000_0048, 32'h0,  5'd6,  T, 32'hCAFE_0001, "ack_at_limit");
        run_txn(4'b1110, 32'h0000_004C, 32'h77, 5'd8,  2, 32'hA5A5_A5A5, "wr_rd_both");
        run_txn(4'b0011, 32'h0000_0003, 32'h0,  5'd31, 0, 32'h0,         "alu_odd_addr");

        for (int i = 0; i < 40; i++) begin
            r_ctrl = 4'($urandom_range(0, 15));
            r_alu  = $urandom;
            if ($urandom_range(0, 3) != 0) r_alu[1:0] = 2'b00;
            r_lat  = $urandom_range(0, T + 1);
            run_txn(r_ctrl, r_alu, $urandom, 5'($urandom_range(0, 31)), r_lat, $urandom, "rand");
        end

        // Reset in the middle of an access, then a late ack that must be ignored.
        ex_control = 4'b0111; ex_alu_result = 32'h80; ex_dst_reg = 5'd2; dmem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mid/req_before", 32'(dmem_req), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ex_control = 4'b0000; ex_alu_result = '0; ex_store_data = '0; ex_dst_reg = '0;
        check("rst_mid/req_after", 32'(dmem_req), 0);
        dmem_ack = 1'b1;
        @(negedge clk); #1;
        check("rst_mid/stall", 32'(stall), 0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        check("rst_mid/req_late", 32'(dmem_req), 0);
        check("rst_mid/wb_rw",    32'(wb_reg_write), 0);
        check("rst_mid/wb_m2r",   32'(wb_mem_to_reg), 0);
        check("rst_mid/wb_data",  wb_mem_data, 0);
        check("rst_mid/wb_dst",   32'(wb_dst_reg), 0);
        check("rst_mid/bus_err",  32'(bus_err), 0);
        $display("[TB] reset_mid_access late_ack ignored check done");

        run_txn(4'b0111, 32'h0000_0100, 32'h0, 5'd10, 2, 32'h600D_CAFE, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
MEM stage of the pipelined MIPS core. It consumes the EX/MEM pipeline register outputs: 4-bit control, ALU result, store data and destination register. It runs the data-memory transaction over a req/ack bus and stalls the upstream pipeline while a load or store is outstanding. It then drives the registered MEM/WB outputs into write-back.

Parameters:
DATA_W, 32, data and address width
REG_W, 5, register index width
ACK_TIMEOUT, 16, maximum ACCESS cycles to wait for dmem_ack before aborting (minimum 2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ex_control  in  [0:3]  from EX/MEM: bit0 MemWrite, bit1 MemRead, bit2 RegWrite, bit3 MemToReg
ex_alu_result  in  DATA_W  effective address, or ALU result for write-back
ex_store_data  in  DATA_W  store data (rs2 value)
ex_dst_reg  in  REG_W  destination register
dmem_req  out  1  memory request, registered
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  DATA_W  word address, registered
dmem_wdata  out  DATA_W  store data, registered
dmem_ack  in  1  one-cycle completion strobe from memory
dmem_rdata  in  DATA_W  load data, valid when dmem_ack=1
stall  out  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM
wb_reg_write  out  1  MEM/WB RegWrite
wb_mem_to_reg  out  1  MEM/WB MemToReg
wb_mem_data  out  DATA_W  MEM/WB load data
wb_alu_result  out  DATA_W  MEM/WB ALU result
wb_dst_reg  out  REG_W  MEM/WB destination register
misalign_err  out  1  one-cycle pulse: memory op with ex_alu_result[1:0] != 0
bus_err  out  1  one-cycle pulse: ACK_TIMEOUT expired

Behaviour:
- Reset: state=IDLE, timeout counter=0, all outputs 0 (dmem_*, wb_*, misalign_err, bus_err). The stall term driven by state is also 0.
- Reset mid-access: rst forces IDLE and drops dmem_req the next edge. A late dmem_ack while in IDLE is ignored.
- Definitions:
  - memop = MemWrite | MemRead.
  - aligned = (ex_alu_result[1:0] == 0).
  - MemWrite has priority when both MemWrite and MemRead are set.
- State IDLE:
  - Non-memop: stall=0. MEM/WB captures ex_* at the edge (1-cycle latency); wb_mem_data=0.
  - memop & !aligned: stall=0, no request. MEM/WB captures a bubble (wb_reg_write=0, wb_mem_to_reg=0). misalign_err=1 for one cycle.
  - memop & aligned: stall=1. At the edge: go to ACCESS, dmem_req<=1, dmem_we<=MemWrite, dmem_addr<=ex_alu_result, dmem_wdata<=ex_store_data. MEM/WB captures a bubble.
- State ACCESS:
  - dmem_req/we/addr/wdata are held stable until completion.
  - stall = !dmem_ack && (counter != ACK_TIMEOUT-1).
  - The counter increments each ACCESS cycle.
- Completion in ACCESS (dmem_ack=1):
  - MEM/WB captures the held ex_* values, which EX/MEM has frozen under stall.
  - Load: wb_mem_data=dmem_rdata. Store: wb_mem_data=0 and wb_mem_to_reg forced 0.
  - Same edge: dmem_req<=0, counter<=0, state<=IDLE. stall is 0 that cycle, so EX/MEM advances at the same edge.
- Timeout (counter == ACK_TIMEOUT-1 with no ack):
  - stall=0, dmem_req<=0, state<=IDLE.
  - MEM/WB captures a bubble; bus_err=1 for one cycle.
- Back-to-back memops: each needs one IDLE cycle plus at least one ACCESS cycle. Minimum 2 cycles per access; no overlap.
- Stalled cycles never write twice: MEM/WB holds a bubble in every cycle where stall=1.
- dmem_ack and timeout in the same cycle: ack wins, normal completion.

Test Plan:
1. ALU op: ex_control=0010, alu=0x1234, dst=7 -> next edge wb_reg_write=1, wb_alu_result=0x1234, wb_dst_reg=7; stall=0 throughout.
2. Load, ack after 3 ACCESS cycles: ex_control=0111, addr=0x40, dmem_rdata=0xDEADBEEF.
   - dmem_req high 3 cycles, addr=0x40, we=0; stall high 3 cycles (IDLE cycle plus 2 ACCESS).
   - Then wb_mem_data=0xDEADBEEF, wb_mem_to_reg=1, wb_reg_write=1.
3. Store, ack first ACCESS cycle: ex_control=1000, addr=0x10, data=0x55 -> dmem_we=1, wdata=0x55; 2-cycle access; wb_reg_write=0.
4. Misaligned load at addr=0x42 -> no dmem_req, misalign_err 1-cycle pulse, wb_reg_write=0, stall=0.
5. Load with no ack, ACK_TIMEOUT=4 -> dmem_req high 4 cycles then low, bus_err pulse, bubble in MEM/WB, state IDLE.
6. rst asserted during ACCESS, then dmem_ack arrives -> dmem_req=0 after edge, all wb_* 0, ack ignored, stall=0.
